// File: rtl/dm_mmio_responder_pkg.sv
// dm_mmio_responder_pkg: shared timer offsets, CTRL bit indices and FSM states
package dm_mmio_responder_pkg;
  localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h0000_7F00;
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_AUTO   = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COUNT, ST_EXPIRED} tmr_state_t;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: down-counting timer with CTRL/PRESET/COUNT/STATUS registers and irq
module mmio_timer
  import dm_mmio_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  tmr_state_t  state, state_nx;
  logic [2:0]  ctrl;
  logic [31:0] preset, count;
  logic        pending;
  logic        ctrl_wr;
  assign ctrl_wr = wr && off == OFF_CTRL;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  // next state: a CTRL write always overrides the natural sequence
  always_comb begin
    state_nx = ctrl_wr ? (wdata[CTRL_EN] ? ST_LOAD : ST_IDLE)
             : state == ST_LOAD    ? (preset == '0 ? ST_EXPIRED : ST_COUNT)
             : state == ST_COUNT   ? (count <= 32'd1 ? ST_EXPIRED : ST_COUNT)
             : state == ST_EXPIRED ? (ctrl[CTRL_AUTO] ? ST_LOAD : ST_IDLE)
             : ST_IDLE;
  end
  // registers: current-state actions still happen on a CTRL write edge; expiry set beats W1C
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr && off == OFF_PRESET) preset <= wdata;
      if (ctrl_wr) ctrl <= wdata[2:0];
      else if (state == ST_EXPIRED && !ctrl[CTRL_AUTO]) ctrl[CTRL_EN] <= 1'b0;
      if (state == ST_LOAD) count <= preset;
      else if (state == ST_COUNT) count <= count - 32'd1;
      if (state == ST_EXPIRED) pending <= 1'b1;
      else if (wr && off == OFF_STATUS && wdata[0]) pending <= 1'b0;
    end
  // outputs: irq from registered bits only, register read mux
  always_comb begin
    irq   = pending & ctrl[CTRL_IRQ_EN];
    rdata = off == OFF_CTRL   ? {29'd0, ctrl}
          : off == OFF_PRESET ? preset
          : off == OFF_COUNT  ? count
          : {31'd0, pending};
  end
endmodule

// File: rtl/dm_mmio_responder.sv
// dm_mmio_responder: data-side RAM plus memory-mapped timer for the single-cycle core
module dm_mmio_responder
  import dm_mmio_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] TIMER_BASE = TIMER_BASE_DEFAULT
) (
  input  logic        clk_I,
  input  logic        reset_I,
  input  logic [31:0] addr_I,
  input  logic [31:0] wdata_I,
  input  logic        we_I,
  output logic [31:0] rdata_O,
  output logic        irq_O
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] idx;
  logic          ram_hit, tmr_hit, unused_ok;
  logic [31:0]   tmr_rdata;
  assign idx       = addr_I[AW+1:2];
  assign tmr_hit   = addr_I[31:4] == TIMER_BASE[31:4];
  assign ram_hit   = addr_I[31:AW+2] == '0 && !tmr_hit;
  assign unused_ok = ^addr_I[1:0];
  // RAM store port; contents are intentionally never reset
  always_ff @(posedge clk_I)
    if (we_I && ram_hit) mem[idx] <= wdata_I;
  // combinational load data; unmapped addresses read zero
  always_comb rdata_O = tmr_hit ? tmr_rdata : ram_hit ? mem[idx] : '0;
  mmio_timer u_timer (
    .clk   (clk_I),
    .rst_n (reset_I),
    .wr    (we_I && tmr_hit),
    .off   (addr_I[3:2]),
    .wdata (wdata_I),
    .rdata (tmr_rdata),
    .irq   (irq_O)
  );
endmodule

// File: tb/tb_dm_mmio_responder.sv
// tb_dm_mmio_responder: directed vectors and timer sequences for dm_mmio_responder
module tb_dm_mmio_responder;
  logic        clk = 0, rst_n = 1, we = 0, irq;
  logic [31:0] addr = 0, wdata = 0, rdata;
  int          tests = 0, fails = 0;
  localparam logic [31:0] T_CTRL = 32'h7F00, T_PRE = 32'h7F04, T_CNT = 32'h7F08, T_ST = 32'h7F0C;

  dm_mmio_responder dut (
    .clk_I   (clk),
    .reset_I (rst_n),
    .addr_I  (addr),
    .wdata_I (wdata),
    .we_I    (we),
    .rdata_O (rdata),
    .irq_O   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    string       name;
  } vec_t;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1;
    @(posedge clk); #1;
    we = 0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 0;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b1, 32'h0000_0010, 32'hDEADBEEF, "ram_wr"},
      '{1'b0, 32'h0000_0010, 32'hDEADBEEF, "ram_rd"},
      '{1'b0, 32'h0000_0013, 32'hDEADBEEF, "ram_rd_byte3"},
      '{1'b1, 32'h4000_0000, 32'h0000_5555, "unmapped_wr"},
      '{1'b0, 32'h4000_0000, 32'h0000_0000, "unmapped_rd"},
      '{1'b0, 32'h0000_0010, 32'hDEADBEEF, "ram_intact"},
      '{1'b1, 32'h0000_0FFC, 32'h1234_5678, "ram_last_wr"},
      '{1'b0, 32'h0000_0FFC, 32'h1234_5678, "ram_last_rd"},
      '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, "ram0_wr"},
      '{1'b1, 32'h0000_1000, 32'h1111_1111, "past_end_wr"},
      '{1'b0, 32'h0000_0000, 32'hA5A5_A5A5, "ram0_no_alias"},
      '{1'b0, 32'h0000_1000, 32'h0000_0000, "past_end_rd"},
      '{1'b1, T_PRE,         32'hCAFE_F00D, "preset_wr"},
      '{1'b0, T_PRE,         32'hCAFE_F00D, "preset_rd"},
      '{1'b1, T_CNT,         32'h0000_0099, "count_wr"},
      '{1'b0, T_CNT,         32'h0000_0000, "count_read_only"},
      '{1'b1, T_CTRL,        32'hFFFF_FFFA, "ctrl_wr"},
      '{1'b0, T_CTRL,        32'h0000_0002, "ctrl_mask"},
      '{1'b0, T_ST,          32'h0000_0000, "status_idle"},
      '{1'b0, 32'h0000_7F10, 32'h0000_0000, "past_timer_rd"}
    };
    #2 rst_n = 0;
    #1 check("reset_irq", {31'd0, irq}, 32'd0);
    rd("reset_ctrl", T_CTRL, 32'd0);
    rd("reset_preset", T_PRE, 32'd0);
    rd("reset_count", T_CNT, 32'd0);
    rd("reset_status", T_ST, 32'd0);
    @(negedge clk) rst_n = 1;
    idle(1);

    for (int i = 0; i < 20; i++)
      if (vecs[i].wr) wr(vecs[i].a, vecs[i].d);
      else rd(vecs[i].name, vecs[i].a, vecs[i].d);

    @(negedge clk);
    addr = 32'h10; wdata = 32'h0BAD_F00D; we = 1;
    #1 check("same_cycle_old", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    we = 0;
    #1 check("after_write_new", rdata, 32'h0BAD_F00D);

    wr(T_PRE, 32'd3);
    wr(T_CTRL, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      check($sformatf("oneshot_irq_e%0d", k), {31'd0, irq}, {31'd0, k == 5});
    end
    rd("oneshot_ctrl", T_CTRL, 32'd2);
    rd("oneshot_count", T_CNT, 32'd0);
    rd("oneshot_status", T_ST, 32'd1);
    wr(T_ST, 32'd1);
    check("oneshot_w1c", {31'd0, irq}, 32'd0);

    wr(T_PRE, 32'd2);
    wr(T_CTRL, 32'd7);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check($sformatf("auto_irq_e%0d", k), {31'd0, irq}, {31'd0, k == 4});
    end
    wr(T_ST, 32'd1);
    check("auto_w1c", {31'd0, irq}, 32'd0);
    idle(2);
    check("auto_before_expiry", {31'd0, irq}, 32'd0);
    wr(T_ST, 32'd1);
    check("w1c_vs_expiry", {31'd0, irq}, 32'd1);
    wr(T_CTRL, 32'd0);
    wr(T_ST, 32'd1);
    check("auto_stop_irq", {31'd0, irq}, 32'd0);
    rd("auto_stop_status", T_ST, 32'd0);

    wr(T_PRE, 32'd10);
    wr(T_CTRL, 32'd3);
    idle(3);
    wr(T_CTRL, 32'd2);
    rd("stop_count", T_CNT, 32'd7);
    idle(5);
    rd("stop_count_hold", T_CNT, 32'd7);
    check("stop_irq", {31'd0, irq}, 32'd0);
    rd("stop_status", T_ST, 32'd0);
    rd("stop_ctrl", T_CTRL, 32'd2);

    wr(32'h20, 32'h1357_9BDF);
    wr(T_PRE, 32'd2);
    wr(T_CTRL, 32'd7);
    idle(4);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    idle(2);
    #2 rst_n = 0;
    #1 check("async_irq", {31'd0, irq}, 32'd0);
    rd("async_ctrl", T_CTRL, 32'd0);
    rd("async_preset", T_PRE, 32'd0);
    rd("async_count", T_CNT, 32'd0);
    rd("async_ram20", 32'h20, 32'h1357_9BDF);
    rd("async_ram10", 32'h10, 32'h0BAD_F00D);
    @(negedge clk) rst_n = 1;
    idle(3);
    check("post_reset_irq", {31'd0, irq}, 32'd0);
    rd("post_reset_count", T_CNT, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
